// File: rtl/flipflop_d_fall_1b.sv
// Falling-edge 1-bit D flip-flop with synchronous active-high clear.
// Latency: out updates at each falling clock edge; no backpressure, always accepts.
module flipflop_d_fall_1b (
  input  logic in,
  output logic out,
  input  logic clock,
  input  logic reset
);

  // Declaration initialiser gives a defined power-up value in simulation;
  // silicon relies on reset instead.
  logic q = 1'b0;

  always_ff @(negedge clock) begin
    if (reset) begin
      q <= 1'b0;
    end else begin
      q <= in;
    end
  end

  assign out = q;

endmodule

// File: tb/tb_flipflop_d_fall_1b.sv
// Randomised and directed bench for flipflop_d_fall_1b against a capture-rule model.
module tb_flipflop_d_fall_1b;

  logic clock;
  logic reset;
  logic in;
  logic out;

  int errors = 0;
  int checks = 0;
  logic exp_q;

  flipflop_d_fall_1b dut (
    .in    (in),
    .out   (out),
    .clock (clock),
    .reset (reset)
  );

  initial clock = 1'b1;
  always #5 clock = ~clock;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: out=%b expected=%b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Called in the high phase; applies d/r for the next falling edge, then
  // disturbs in/reset while clock is low and across the rising edge.
  task automatic step(input logic d, input logic r, input string tag);
    in = d;
    reset = r;
    @(negedge clock);
    exp_q = r ? 1'b0 : d;
    #1 check_bit({tag, "_fall"}, out, exp_q);
    in = ~d;
    reset = ~r;
    #1 in = d;
    reset = r;
    #1 in = 1'($urandom);
    reset = 1'($urandom);
    #1 check_bit({tag, "_low"}, out, exp_q);
    @(posedge clock);
    #1 check_bit({tag, "_rise"}, out, exp_q);
  endtask

  initial begin
    in = 1'b0;
    reset = 1'b0;
    #1 check_bit("powerup", out, 1'b0);

    step(1'b0, 1'b0, "flush");
    step(1'b1, 1'b0, "capture1");
    step(1'b1, 1'b0, "hold");
    step(1'b0, 1'b0, "capture0");
    step(1'b0, 1'b0, "stay0");
    step(1'b1, 1'b0, "preset1");
    step(1'b1, 1'b1, "rst_priority");
    step(1'b1, 1'b0, "after_rst");
    step(1'b0, 1'b1, "rst_with0");
    step(1'b1, 1'b1, "rst_hold");

    for (int i = 0; i < 300; i++) begin
      step(1'($urandom), ($urandom_range(3, 0) == 0), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
